// File: rtl/spin_payout.sv
// spin_payout: charges the bet, grades the three reels and credits the win.
// Optional SPIN_PAYOUT_BCD_EN adds a serial binary-to-BCD view of the balance.
module spin_payout #(
    parameter int         CREDIT_W      = 10,
    parameter int         START_CREDITS = 100,
    parameter int         MAX_CREDITS   = 999,
    parameter int         PAIR_MULT     = 2,
    parameter int         TRIPLE_MULT   = 10,
    parameter int         JACKPOT_MULT  = 50,
    parameter logic [3:0] JACKPOT_SYM   = 4'h7
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [2:0]          bet,
    input  logic                spin_start,
    input  logic                spin_done,
    input  logic [11:0]         PlayerSpin,
    output logic [CREDIT_W-1:0] credits,
    output logic [8:0]          win_amount,
    output logic                win_valid,
    output logic                reject,
    output logic                busy,
`ifdef SPIN_PAYOUT_BCD_EN
    output logic                game_over,
    output logic [11:0]         credits_bcd,
    output logic                bcd_valid
`else
    output logic                game_over
`endif
);
    typedef enum logic [2:0] {IDLE, SPINNING, EVAL, PAY, CREDIT} state_t;
    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [2:0]          bet_q, bet_d;
    logic [11:0]         spin_q, spin_d;
    logic [5:0]          mult_q, mult_d;
    logic [8:0]          win_q, win_d;
    logic                win_valid_q, win_valid_d, reject_q, reject_d, busy_q;
    logic [CREDIT_W:0]   sum;
    logic                eq12, eq23, eq13;
    assign eq12 = spin_q[11:8] == spin_q[7:4];
    assign eq23 = spin_q[7:4] == spin_q[3:0];
    assign eq13 = spin_q[11:8] == spin_q[3:0];
    // one extra bit so the win can never wrap the balance before saturation
    assign sum = {1'b0, credits_q} + (CREDIT_W+1)'(win_q);
    always_comb begin
        state_d     = state_q;
        credits_d   = credits_q;
        bet_d       = bet_q;
        spin_d      = spin_q;
        mult_d      = mult_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        reject_d    = 1'b0;
        case (state_q)
            IDLE: if (spin_start) begin
                if (bet == 3'd0 || credits_q < CREDIT_W'(bet)) reject_d = 1'b1;
                else begin
                    bet_d     = bet;
                    credits_d = credits_q - CREDIT_W'(bet);
                    state_d   = SPINNING;
                end
            end
            SPINNING: if (spin_done) begin
                spin_d  = PlayerSpin;
                state_d = EVAL;
            end
            EVAL: begin
                mult_d  = (eq12 && eq23) ? ((spin_q[3:0] == JACKPOT_SYM) ? 6'(JACKPOT_MULT) : 6'(TRIPLE_MULT))
                        : (eq12 || eq23 || eq13) ? 6'(PAIR_MULT) : 6'd0;
                state_d = PAY;
            end
            PAY: begin
                win_d   = 9'(bet_q) * 9'(mult_q);
                state_d = CREDIT;
            end
            CREDIT: begin
                credits_d   = (sum > (CREDIT_W+1)'(MAX_CREDITS)) ? CREDIT_W'(MAX_CREDITS) : sum[CREDIT_W-1:0];
                win_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= IDLE;
            credits_q   <= CREDIT_W'(START_CREDITS);
            bet_q       <= 3'd0;
            spin_q      <= 12'd0;
            mult_q      <= 6'd0;
            win_q       <= 9'd0;
            win_valid_q <= 1'b0;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            bet_q       <= bet_d;
            spin_q      <= spin_d;
            mult_q      <= mult_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            reject_q    <= reject_d;
            busy_q      <= state_q != IDLE;
        end
    end
    assign credits    = credits_q;
    assign win_amount = win_q;
    assign win_valid  = win_valid_q;
    assign reject     = reject_q;
    assign busy       = busy_q;
    assign game_over  = credits_q == '0 && state_q == IDLE;
`ifdef SPIN_PAYOUT_BCD_EN
    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    localparam logic [11:0] START_BCD = to_bcd(START_CREDITS);
    logic [CREDIT_W-1:0]         src_q, sh_q;
    logic [11:0]                 acc_q, out_q, adj;
    logic [$clog2(CREDIT_W+1)-1:0] cnt_q;
    logic                        conv_q;
    always_comb begin
        for (int k = 0; k < 3; k++)
            adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    end
    // a new balance restarts the shift-add-3 sequence from scratch
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            src_q  <= CREDIT_W'(START_CREDITS);
            sh_q   <= '0;
            acc_q  <= '0;
            out_q  <= START_BCD;
            cnt_q  <= '0;
            conv_q <= 1'b0;
        end else if (credits_q != src_q) begin
            src_q  <= credits_q;
            sh_q   <= credits_q;
            acc_q  <= '0;
            cnt_q  <= ($clog2(CREDIT_W+1))'(CREDIT_W);
            conv_q <= 1'b1;
        end else if (conv_q) begin
            sh_q  <= sh_q << 1;
            acc_q <= {adj[10:0], sh_q[CREDIT_W-1]};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 1) begin
                out_q  <= {adj[10:0], sh_q[CREDIT_W-1]};
                conv_q <= 1'b0;
            end
        end
    end
    assign credits_bcd = out_q;
    assign bcd_valid   = !conv_q && credits_q == src_q;
`endif
endmodule

// File: tb/tb_spin_payout.sv
// tb_spin_payout: directed vectors with hand-computed balances and wins.
module tb_spin_payout;
    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] bet = 3'd0;
    logic       spin_start = 1'b0;
    logic       spin_done = 1'b0;
    logic [11:0] PlayerSpin = 12'd0;
    logic [9:0] credits;
    logic [8:0] win_amount;
    logic       win_valid, reject, busy, game_over;
`ifdef SPIN_PAYOUT_BCD_EN
    logic [11:0] credits_bcd;
    logic        bcd_valid;
`endif
    int n_pass = 0;
    int n_total = 0;

    spin_payout dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .bet(bet), .spin_start(spin_start),
        .spin_done(spin_done), .PlayerSpin(PlayerSpin), .credits(credits),
        .win_amount(win_amount), .win_valid(win_valid), .reject(reject), .busy(busy),
`ifdef SPIN_PAYOUT_BCD_EN
        .game_over(game_over), .credits_bcd(credits_bcd), .bcd_valid(bcd_valid)
`else
        .game_over(game_over)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        spin_start = 1'b0;
        spin_done = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic spin(input logic [2:0] b, input logic [11:0] reels, input int charged, input int win, input int fin);
        bet = b;
        spin_start = 1'b1;
        tick();
        spin_start = 1'b0;
        chk("charge", credits, charged);
        chk("no_reject", reject, 0);
        tick();
        chk("busy", busy, 1);
        PlayerSpin = reels;
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        tick();
        tick();
        chk("wv_early", win_valid, 0);
        tick();
        chk("wv", win_valid, 1);
        chk("win", win_amount, win);
        chk("credits", credits, fin);
        chk("busy_tail", busy, 1);
        tick();
        chk("wv_pulse", win_valid, 0);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        do_reset();
        chk("rst_credits", credits, 100);
        chk("rst_win", win_amount, 0);
        chk("rst_wv", win_valid, 0);
        chk("rst_reject", reject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_game_over", game_over, 0);
`ifdef SPIN_PAYOUT_BCD_EN
        begin
            int n = 0;
            chk("rst_bcd", credits_bcd, 12'h100);
            chk("rst_bcd_valid", bcd_valid, 1);
            bet = 3'd5;
            spin_start = 1'b1;
            tick();
            spin_start = 1'b0;
            while (bcd_valid == 1'b0 && n < 20) begin
                n++;
                tick();
            end
            chk("bcd_latency", n, 11);
            chk("bcd_95", credits_bcd, 12'h095);
            chk("bcd_valid_back", bcd_valid, 1);
            do_reset();
        end
`endif
        spin(3'd5, 12'h777, 95, 250, 345);
        spin(3'd3, 12'h33A, 342, 6, 348);
        spin(3'd3, 12'h5A5, 345, 6, 351);
        spin(3'd3, 12'h123, 348, 0, 348);

        do_reset();
        for (int i = 0; i < 13; i++) spin(3'd7, 12'h123, 100 - 7 * (i + 1), 0, 100 - 7 * (i + 1));
        spin(3'd6, 12'h123, 3, 0, 3);
        bet = 3'd5;
        spin_start = 1'b1;
        tick();
        spin_start = 1'b0;
        chk("rej_low", reject, 1);
        chk("rej_credits", credits, 3);
        chk("rej_busy", busy, 0);
        tick();
        chk("rej_pulse", reject, 0);
        chk("rej_busy2", busy, 0);
        bet = 3'd0;
        spin_start = 1'b1;
        tick();
        spin_start = 1'b0;
        chk("rej_zero", reject, 1);
        chk("rej_zero_credits", credits, 3);
        spin(3'd3, 12'h123, 0, 0, 0);
        chk("game_over", game_over, 1);
        bet = 3'd1;
        spin_start = 1'b1;
        tick();
        spin_start = 1'b0;
        chk("rej_broke", reject, 1);
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("idle_done_wv", win_valid, 0);
            chk("idle_done_busy", busy, 0);
            tick();
        end

        do_reset();
        spin(3'd7, 12'h777, 93, 350, 443);
        spin(3'd7, 12'h777, 436, 350, 786);
        spin(3'd7, 12'h111, 779, 70, 849);
        spin(3'd7, 12'h111, 842, 70, 912);
        spin(3'd7, 12'h111, 905, 70, 975);
        spin(3'd7, 12'h113, 968, 14, 982);
        spin(3'd7, 12'h113, 975, 14, 989);
        spin(3'd1, 12'h113, 988, 2, 990);
        spin(3'd7, 12'h777, 983, 350, 999);

        bet = 3'd5;
        spin_start = 1'b1;
        tick();
        spin_start = 1'b0;
        chk("mid_charge", credits, 994);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_rst_credits", credits, 100);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_win", win_amount, 0);
        PlayerSpin = 12'h777;
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_wv", win_valid, 0);
            chk("post_rst_credits", credits, 100);
            tick();
        end
        chk("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
